mnist_frame_loader: RTL

Writer side of the neuron's image buffer. Accepts an 8-bit pixel byte stream with a valid/ready handshake and fills a PIXELS-entry frame buffer. Signals a complete frame to the downstream ANN neuron array and serves the neuron's synchronous pixel reads. Holds the stream off until the consumer acknowledges the frame. It replaces file-preloaded image memory in synthesizable builds.

---
 rtl/mnist_frame_loader_if.sv | 12 +
 rtl/mnist_frame_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mnist_frame_loader_if.sv
// rtl/mnist_frame_loader_if.sv - pixel byte stream handshake into the frame loader
interface mnist_frame_loader_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_sof;
   logic              in_ready;

   modport master (output in_data, output in_valid, output in_sof, input in_ready);
   modport slave  (input in_data, input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/mnist_frame_loader.sv
// rtl/mnist_frame_loader.sv - fills a frame buffer from a pixel stream and serves neuron reads
module mnist_frame_loader #(
   parameter int PIXELS = 784,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   mnist_frame_loader_if.slave s_in,
   input  logic [ADDR_W-1:0]   i_rd_addr,
   output logic [DATA_W-1:0]   o_rd_data,
   output logic                o_frame_valid,
   input  logic                i_frame_ack,
   output logic                o_frame_error,
   output logic [7:0]          o_frame_count
);

   typedef enum logic {ST_LOAD, ST_FULL} state_t;

   localparam logic [ADDR_W-1:0] LP_LAST   = ADDR_W'(PIXELS - 1);
   localparam logic [ADDR_W:0]   LP_PIXELS = (ADDR_W + 1)'(PIXELS);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_live;
   logic [ADDR_W-1:0]   r_wr_cnt;
   logic [ADDR_W-1:0]   w_wr_cnt_nxt;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic                w_wr_en;
   logic                w_err_nxt;
   logic                w_frame_done;
   logic                w_accept;
   logic                w_rd_in_range;
   logic                r_frame_error;
   logic [7:0]          r_frame_count;
   logic [DATA_W-1:0]   r_rd_data;
   logic [DATA_W-1:0]   r_mem [0:PIXELS-1];

   // in_ready stays low while in reset and becomes live on the first edge after release
   assign s_in.in_ready = r_live && (r_state == ST_LOAD);
   assign o_frame_valid = (r_state == ST_FULL);
   assign o_frame_error = r_frame_error;
   assign o_frame_count = r_frame_count;
   assign o_rd_data     = r_rd_data;
   assign w_accept      = s_in.in_valid && s_in.in_ready;
   assign w_rd_in_range = {1'b0, i_rd_addr} < LP_PIXELS;

   // State register plus the post-reset liveness flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_LOAD;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
      end
   end

   // Next state, write strobe/address and write counter update
   always_comb begin
      w_state_nxt  = r_state;
      w_wr_cnt_nxt = r_wr_cnt;
      w_wr_addr    = r_wr_cnt;
      w_wr_en      = 1'b0;
      w_err_nxt    = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (w_accept) begin
               w_wr_en = 1'b1;
               if (s_in.in_sof && (r_wr_cnt != '0)) begin
                  // Resync: drop the partial frame, this beat becomes pixel 0
                  w_wr_addr    = '0;
                  w_wr_cnt_nxt = ADDR_W'(1);
                  w_err_nxt    = 1'b1;
               end else if (r_wr_cnt == LP_LAST) begin
                  w_wr_cnt_nxt = '0;
                  w_state_nxt  = ST_FULL;
                  w_frame_done = 1'b1;
               end else begin
                  w_wr_cnt_nxt = r_wr_cnt + ADDR_W'(1);
               end
            end
         end
         ST_FULL: begin
            if (i_frame_ack) begin
               w_state_nxt = ST_LOAD;
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Write counter, error pulse and completed-frame counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt      <= '0;
         r_frame_error <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_wr_cnt      <= w_wr_cnt_nxt;
         r_frame_error <= w_err_nxt;
         if (w_frame_done) begin
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   // Buffer write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= s_in.in_data;
      end
   end

   // Registered read port; out-of-range addresses read as zero, same-address write returns old data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (w_rd_in_range) begin
         r_rd_data <= r_mem[i_rd_addr];
      end else begin
         r_rd_data <= '0;
      end
   end

endmodule
